// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID register, with stall, redirect/squash and fault-halt handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        running,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    // One bit wider than the PC so the byte limit is representable for any depth.
    localparam logic [32:0] LIMIT = 33'(IMEM_DEPTH) << 2;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_fault;
    logic [31:0] r_fault_addr;
    logic [15:0] r_fetch_count;

    logic [32:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_target_bad;

    always_comb begin
        w_pc_plus4   = {1'b0, r_pc} + 33'd4;
        w_next_pc    = (w_pc_plus4 == LIMIT) ? '0 : w_pc_plus4[31:0];
        w_target_bad = (redirect_target[1:0] != 2'b00) ||
                       ({1'b0, redirect_target} >= LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_pc            <= RESET_PC;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= '0;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus4 <= '0;
            r_fault         <= 1'b0;
            r_fault_addr    <= '0;
            r_fetch_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Redirect outranks stall; an illegal target halts without moving the PC.
                    if (redirect_valid && w_target_bad) begin
                        r_state      <= S_HALTED;
                        r_fault      <= 1'b1;
                        r_fault_addr <= redirect_target;
                        r_ifid_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        r_pc         <= redirect_target;
                        r_ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        r_ifid_instr    <= instr_in;
                        r_ifid_pc       <= r_pc;
                        r_ifid_pc_plus4 <= w_next_pc;
                        r_ifid_valid    <= 1'b1;
                        r_pc            <= w_next_pc;
                        r_fetch_count   <= r_fetch_count + 16'd1;
                    end
                end
                S_HALTED: begin
                    r_ifid_valid <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ifid_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out        = r_pc;
    assign ifid_valid    = r_ifid_valid;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign running       = (r_state == S_RUN);
    assign fault         = r_fault;
    assign fault_addr    = r_fault_addr;
    assign fetch_count   = r_fetch_count;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the mini-MIPS core. Owns the program counter, drives the instruction memory read address, and captures the returned word into the IF/ID pipeline register for decode. Supports stall, branch/jump redirect with wrong-path squash, and a fault halt. Sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset. Word-aligned and below IMEM_DEPTH*4.
- IMEM_DEPTH, 256, number of instruction-memory words. The legal PC range is 0 .. IMEM_DEPTH*4-4.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-shot request to leave IDLE and begin fetching.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  new PC for the redirect.
- instr_in  in  32  instruction memory read data; a combinational function of pc_out.
- pc_out  out  32  registered PC, drives the instruction memory address.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  fetched instruction.
- ifid_pc  out  32  address of ifid_instr.
- ifid_pc_plus4  out  32  ifid_pc + 4, wrapped.
- running  out  1  high while the FSM is in RUN.
- fault  out  1  sticky; an illegal redirect target was seen.
- fault_addr  out  32  the offending redirect_target.
- fetch_count  out  16  count of instructions loaded into IF/ID; wraps modulo 2^16.

## Operation
FSM states:
- IDLE:
  - pc_out = RESET_PC; ifid_valid = 0; stall and redirect are ignored.
  - start=1 moves to RUN on the next edge.
- RUN: per-edge priority, highest first.
  1. redirect_valid with an illegal target, i.e. target[1:0] != 0 or target >= IMEM_DEPTH*4:
     - Go to HALTED; fault <= 1; fault_addr <= target; ifid_valid <= 0; PC holds.
  2. redirect_valid with a legal target:
     - PC <= target; ifid_valid <= 0, squashing the wrong-path word.
     - The IF/ID data fields hold their previous values.
     - Redirect overrides stall.
  3. stall=1: PC and all IF/ID fields hold, including ifid_valid.
  4. Otherwise:
     - ifid_instr <= instr_in; ifid_pc <= PC; ifid_pc_plus4 <= next; ifid_valid <= 1.
     - PC <= next, where next = (PC+4 == IMEM_DEPTH*4) ? 0 : PC+4.
     - fetch_count increments.
  - start is ignored in RUN.
- HALTED:
  - All state holds; ifid_valid = 0; all inputs are ignored.
  - Only rst_n exits HALTED.

Width and arithmetic rules:
- The PC is 32 bits, and bits [1:0] are always 0.
- The PC+4 wrap applies both to the PC and to ifid_pc_plus4.

## Timing
- Reset (asynchronous, immediate on rst_n low, including mid-RUN):
  - state = IDLE; pc_out = RESET_PC; running = 0; fault = 0.
  - ifid_valid = 0; ifid_instr, ifid_pc, ifid_pc_plus4, fault_addr and fetch_count = 0.
  - Deassertion is sampled on the next rising edge.
- All outputs are registered. running is decoded directly from the state register.
- instr_in must settle within the same cycle as pc_out (asynchronous memory read).
- Fetch latency: the word at address A appears on ifid_instr one edge after pc_out = A, provided there is no stall or redirect in that cycle.
- Redirect latency:
  - The redirect target appears on pc_out one edge after redirect_valid.
  - The instruction at the target is valid in IF/ID two edges after redirect_valid.
- start → RUN after one edge. The first valid IF/ID word (at RESET_PC) appears one edge later.
- Throughput is one instruction per cycle with no stalls.

## Test plan
Memory word i holds 0xA000_0000 + i throughout.
- Reset, then start=1 for one cycle, with RESET_PC=0:
  - running=1 after one edge.
  - On following edges, IF/ID shows (0xA0000000, pc 0x0), then (0xA0000001, pc 0x4), then (0xA0000002, pc 0x8).
  - fetch_count=3.
- stall=1 for 2 cycles while pc_out=0x8:
  - pc_out stays 0x8 and IF/ID holds pc 0x4, valid=1, for both cycles.
  - After stall drops, IF/ID=(0xA0000002, 0x8) and there are no duplicate fetches.
- redirect to 0x40 while pc_out=0x10, with stall=1 in the same cycle:
  - Next edge: pc_out=0x40, ifid_valid=0.
  - Edge after that: IF/ID=(0xA0000010, 0x40, plus4 0x44).
- redirect to 0x42 (misaligned) while pc_out=0x10:
  - fault=1, fault_addr=0x42, running=0, ifid_valid=0, pc_out stays 0x10.
  - Later start, redirect and stall pulses have no effect.
- Wrap with IMEM_DEPTH=256:
  - Redirect to 0x3FC, then free-run.
  - IF/ID=(0xA00000FF, 0x3FC, plus4 0x0); the next IF/ID is (0xA0000000, 0x0).
- Redirect to 0x400 (out of range): fault=1, fault_addr=0x400. Then rst_n low mid-cycle: all outputs return to their reset values immediately, and state is IDLE.
